// File: rtl/nanorv32_intc_if.sv
// Core-facing irq/ack/return handshake plus the word-addressed configuration port.
// master = interrupt controller side, slave = core / SoC side.
interface nanorv32_intc_if;
    logic        irq;
    logic [4:0]  irq_id;
    logic        in_service;
    logic        irq_ack;
    logic        reti_inst_detected;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (
        output irq, irq_id, in_service, cfg_rdata,
        input  irq_ack, reti_inst_detected, cfg_wr, cfg_addr, cfg_wdata
    );
    modport slave (
        input  irq, irq_id, in_service, cfg_rdata,
        output irq_ack, reti_inst_detected, cfg_wr, cfg_addr, cfg_wdata
    );
endinterface

// File: rtl/nanorv32_intc.sv
// nanorv32 interrupt controller: per-source edge/level pending, fixed priority, REQ/SERVICE tracking.
// Optional NANORV32_INTC_SYNC_EN adds a two-flop synchronizer per source ahead of sensing.
module nanorv32_intc_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic src_raw,
    input  logic edge_mode,
    input  logic to_edge,
    input  logic clr,
    output logic pend
);
    logic src, rise, src_dly_q, pend_q, pend_d;

`ifdef NANORV32_INTC_SYNC_EN
    logic sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= src_raw;
            sync2_q <= sync1_q;
        end
    end
    assign src = sync2_q;
`else
    assign src = src_raw;
`endif

    assign rise = src & ~src_dly_q;

    // A fresh edge always wins over W1C / ack; leaving level mode drops the level copy.
    always_comb begin
        pend_d = src;
        if (edge_mode)    pend_d = rise | (pend_q & ~clr);
        else if (to_edge) pend_d = rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_dly_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            src_dly_q <= src;
            pend_q    <= pend_d;
        end
    end

    assign pend = pend_q;
endmodule

module nanorv32_intc #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_src,
    nanorv32_intc_if.master    bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state_q;
    logic               irq_q, in_service_q;
    logic [4:0]         irq_id_q;
    logic [NUM_IRQ-1:0] enable_q, enable_d, edge_sel_q, edge_sel_d;
    logic [NUM_IRQ-1:0] pending, wdata, w1c, to_edge, id_sel, clr;
    logic               wr_en, wr_pend, wr_edge, ack_fire, still_pend, cand_vld;
    logic [4:0]         cand_id;

    assign wdata   = bus.cfg_wdata[NUM_IRQ-1:0];
    assign wr_en   = bus.cfg_wr && (bus.cfg_addr == 2'd0);
    assign wr_pend = bus.cfg_wr && (bus.cfg_addr == 2'd1);
    assign wr_edge = bus.cfg_wr && (bus.cfg_addr == 2'd2);

    always_comb begin
        enable_d   = enable_q;
        edge_sel_d = edge_sel_q;
        if (wr_en)   enable_d   = wdata;
        if (wr_edge) edge_sel_d = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q   <= '0;
            edge_sel_q <= '0;
        end else begin
            enable_q   <= enable_d;
            edge_sel_q <= edge_sel_d;
        end
    end

    assign ack_fire = (state_q == REQ) && bus.irq_ack;
    assign w1c      = wr_pend ? wdata : '0;
    assign to_edge  = wr_edge ? (wdata & ~edge_sel_q) : '0;

    always_comb begin
        id_sel = '0;
        for (int i = 0; i < NUM_IRQ; i++) id_sel[i] = (irq_id_q == 5'(i));
    end

    assign clr = w1c | (ack_fire ? id_sel : '0);

    nanorv32_intc_lane u_lane [NUM_IRQ-1:0] (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_raw   (irq_src),
        .edge_mode (edge_sel_q),
        .to_edge   (to_edge),
        .clr       (clr),
        .pend      (pending)
    );

    // Scan high to low so the lowest index is the last (winning) assignment.
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i] && enable_q[i]) begin
                cand_vld = 1'b1;
                cand_id  = 5'(i);
            end
        end
    end

    assign still_pend = |(pending & enable_q & id_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cand_vld) begin
                    irq_id_q <= cand_id;
                    irq_q    <= 1'b1;
                    state_q  <= REQ;
                end
                REQ: if (bus.irq_ack) begin
                    irq_q        <= 1'b0;
                    in_service_q <= 1'b1;
                    state_q      <= SERVICE;
                end else if (!still_pend) begin
                    irq_q   <= 1'b0;
                    state_q <= IDLE;
                end
                SERVICE: if (bus.reti_inst_detected) begin
                    in_service_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    irq_q        <= 1'b0;
                    in_service_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq        = irq_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.in_service = in_service_q;

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            2'd0: bus.cfg_rdata[NUM_IRQ-1:0] = enable_q;
            2'd1: bus.cfg_rdata[NUM_IRQ-1:0] = pending;
            2'd2: bus.cfg_rdata[NUM_IRQ-1:0] = edge_sel_q;
            default: begin
                bus.cfg_rdata[4:0] = irq_id_q;
                bus.cfg_rdata[8]   = in_service_q;
                bus.cfg_rdata[9]   = irq_q;
            end
        endcase
    end
endmodule

// File: doc/nanorv32_intc.md
# nanorv32_intc

Interrupt controller for the nanorv32 core: the requesting side of the core's `irq` / `irq_ack` / `reti_inst_detected` handshake. It collects up to 32 peripheral interrupt sources and latches them as pending, with edge or level sensing per source. It arbitrates by fixed priority, raises `irq` towards the pipeline flow controller, and tracks the in-service interrupt until the core retires its return-from-interrupt. It sits beside the core in the SoC top and exposes a small word-addressed configuration port.

## Interface
- `NUM_IRQ`, 8: number of sources, 1..32.
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `irq_src` input NUM_IRQ: raw peripheral interrupt lines, active high.
- `irq` output 1: interrupt request to the core.
- `irq_id` output 5: index of the requested or in-service source.
- `in_service` output 1: high from acceptance until return.
- `irq_ack` input 1: one-cycle pulse from the core when it accepts `irq`.
- `reti_inst_detected` input 1: one-cycle pulse when the core retires the interrupt return.
- `cfg_wr` input 1: configuration write strobe.
- `cfg_addr` input 2: register select.
- `cfg_wdata` input 32: write data.
- `cfg_rdata` output 32: read data, combinational from `cfg_addr`.

## Operation
- **Registers** (bits above `NUM_IRQ` read 0, writes ignored):
  - 0 ENABLE: RW.
  - 1 PENDING: read; write-1-to-clear, edge sources only.
  - 2 EDGE_SEL: RW; 1 = rising edge, 0 = level.
  - 3 STATUS: read; [4:0] = `irq_id`, [8] = `in_service`, [9] = `irq`.
- **Edge source**: a rising edge (`src & ~src_d`) sets PENDING. The bit clears on W1C or on `irq_ack` for that source. A hardware set wins over a clear in the same cycle.
- **Level source**: PENDING is the registered source level. W1C and ack have no effect.
- **Candidate**: lowest index in `PENDING & ENABLE`. Index 0 has the highest priority.
- **State machine**, registered:
  - IDLE: if any candidate exists, latch its index into `irq_id` and go to REQ.
  - REQ: `irq`=1.
    - `irq_ack` → clear edge pending for `irq_id`, go to SERVICE.
    - Otherwise, if the latched source is no longer pending or enabled → IDLE.
    - Ack wins over withdrawal in the same cycle.
    - `irq_id` is frozen while in REQ; a higher-priority arrival does not pre-empt.
  - SERVICE: `irq`=0, `in_service`=1. `reti_inst_detected` → IDLE.
- No nesting.
- `irq_ack` outside REQ and `reti_inst_detected` outside SERVICE are ignored.
- Changing EDGE_SEL from level to edge clears that source's PENDING bit in the same write.

## Timing
- **Reset values**: all registers 0, state IDLE, `irq`=0, `irq_id`=0, `in_service`=0, `cfg_rdata` reflects the zeroed registers.
- **Reset mid-operation**: everything returns to these values immediately; the core's pending request is dropped.
- **Latency**:
  - Without synchronizer: source rising at edge N → PENDING set at edge N+1 → `irq` high after edge N+2.
  - With synchronizer: +2 cycles.
- `irq` drops the cycle after the `irq_ack` edge.
- After `reti_inst_detected`, a re-request of a still-pending source asserts `irq` 2 cycles later (IDLE, then REQ).
- A config write takes effect at the clock edge; `cfg_rdata` shows the new value the following cycle.

## Configuration
- `NANORV32_INTC_SYNC_EN` defined: each `irq_src` bit passes through a two-flop synchronizer before edge detection and level sampling. Asynchronous sources are legal, at +2 cycles of latency.
- Not defined: `irq_src` must be synchronous to `clk`; only the single edge-detect flop is present.

## Test plan
- **Edge request and return**: reset, ENABLE=0x01, EDGE_SEL=0x01, pulse `irq_src[0]` for 1 cycle → `irq`=1 and `irq_id`=0 two cycles after the rise (four with the macro); `irq_ack` → `irq`=0, `in_service`=1, PENDING=0; `reti_inst_detected` → `in_service`=0, state IDLE.
- **Priority**: ENABLE=0xFF, all edge, raise sources 5 and 2 in the same cycle → `irq_id`=2. After ack and reti → `irq_id`=5 requested 2 cycles later.
- **Level re-request**: EDGE_SEL=0, hold `irq_src[3]` high through ack and reti → `irq` reasserts with `irq_id`=3. Drop the source while in SERVICE, then reti → no request.
- **Withdrawal**: in REQ, write ENABLE=0 → `irq`=0 next cycle, state IDLE. Repeat with the same-cycle `irq_ack` → SERVICE entered.
- **Set/clear collisions**: new edge on source 1 in the same cycle as its `irq_ack` → PENDING[1] stays 1. W1C 0x02 in the same cycle as a rising edge → PENDING[1]=1.
- **Async reset**: assert `rst_n` low while in SERVICE → `in_service`, `irq`, and registers read 0 with no clock edge.
